// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-way fully associative cache set controller.
package cache_pkg;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned WAY_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_RD,
        MEM_WR,
        RESP
    } state_t;

    // Word-granular tag: byte-offset bits [1:0] are dropped.
    function automatic int unsigned tag_w(input int unsigned addr_w);
        return addr_w - 2;
    endfunction

endpackage

// File: rtl/cache_ctrl_4way_if.sv
// CPU, memory and lru-side signals of the cache set controller.
// slave is the controller; master is the surrounding system.
interface cache_ctrl_4way_if
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic [WAY_W-1:0]  lru_way;
    logic              lru_hit;
    logic              lru_en;
    logic [WAY_W-1:0]  lru_victim;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  lru_way, lru_hit, lru_en,
        output lru_victim
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output lru_way, lru_hit, lru_en,
        input  lru_victim
    );

endinterface

// File: rtl/cache_tag_match.sv
// Valid-gated tag comparators for the four ways with lowest-index priority
// for both the hit way and the first free way.
module cache_tag_match
    import cache_pkg::*;
#(
    parameter int unsigned TAG_W = 30
) (
    input  logic [TAG_W-1:0] tag,
    input  logic [WAYS-1:0]  valid,
    input  logic [TAG_W-1:0] tags [WAYS],
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic             any_invalid,
    output logic [WAY_W-1:0] first_invalid
);

    // Scan from the top way down so the lowest matching index is written last.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!valid[i]) begin
                any_invalid   = 1'b1;
                first_invalid = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_4way.sv
// Write-through, no-write-allocate controller for one 4-way fully associative
// set; drives the lru block and takes its victim for refills.
module cache_ctrl_4way
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic              clk,
    input logic              reset,
    cache_ctrl_4way_if.slave bus
);

    localparam int unsigned TAG_W = tag_w(ADDR_W);

    state_t            state;
    logic [WAYS-1:0]   valid;
    logic [TAG_W-1:0]  tags [WAYS];
    logic [DATA_W-1:0] data [WAYS];

    logic              req_we;
    logic [TAG_W-1:0]  req_tag;
    logic [WAY_W-1:0]  fill_way;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              any_invalid;
    logic [WAY_W-1:0]  first_invalid;

    cache_tag_match #(
        .TAG_W (TAG_W)
    ) u_tag_match (
        .tag           (req_tag),
        .valid         (valid),
        .tags          (tags),
        .hit           (hit),
        .hit_way       (hit_way),
        .any_invalid   (any_invalid),
        .first_invalid (first_invalid)
    );

    // Tag/data arrays are written here but deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            req_we        <= 1'b0;
            req_tag       <= '0;
            fill_way      <= '0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_done  <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.lru_way   <= '0;
            bus.lru_hit   <= 1'b0;
            bus.lru_en    <= 1'b0;
        end else begin
            bus.cpu_done <= 1'b0;
            bus.lru_en   <= 1'b0;
            bus.lru_hit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        bus.cpu_ready <= 1'b0;
                        req_we        <= bus.cpu_we;
                        req_tag       <= bus.cpu_addr[ADDR_W-1:2];
                        bus.mem_addr  <= bus.cpu_addr & ~ADDR_W'(3);
                        bus.mem_wdata <= bus.cpu_wdata;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        bus.lru_en  <= 1'b1;
                        bus.lru_hit <= 1'b1;
                        bus.lru_way <= hit_way;
                        if (req_we) begin
                            data[hit_way] <= bus.mem_wdata;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= 1'b1;
                            state         <= MEM_WR;
                        end else begin
                            bus.cpu_rdata <= data[hit_way];
                            bus.cpu_done  <= 1'b1;
                            state         <= RESP;
                        end
                    end else begin
                        bus.mem_req <= 1'b1;
                        bus.mem_we  <= req_we;
                        if (req_we) begin
                            state <= MEM_WR;
                        end else begin
                            // Never evict while a free way exists.
                            fill_way <= any_invalid ? first_invalid : bus.lru_victim;
                            state    <= MEM_RD;
                        end
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        tags[fill_way]  <= req_tag;
                        data[fill_way]  <= bus.mem_rdata;
                        valid[fill_way] <= 1'b1;
                        bus.cpu_rdata   <= bus.mem_rdata;
                        bus.lru_en      <= 1'b1;
                        bus.lru_hit     <= 1'b1;
                        bus.lru_way     <= fill_way;
                        bus.mem_req     <= 1'b0;
                        bus.mem_we      <= 1'b0;
                        bus.cpu_done    <= 1'b1;
                        state           <= RESP;
                    end
                end
                MEM_WR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req  <= 1'b0;
                        bus.mem_we   <= 1'b0;
                        bus.cpu_done <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    bus.cpu_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.cpu_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_ctrl_4way.md
Name: cache_ctrl_4way

Overview:
- Controller for one 4-way fully associative cache set (4 lines, 1 word per line). Write-through, no-write-allocate.
- Sits directly upstream of the lru block. It performs tag match and drives lineIndex/hit/enable into lru.
- It consumes lruOut as the victim way for refills.
- It also handles the CPU-side request/done handshake and the memory-side req/ack handshake.

Parameters:
- ADDR_W, 32, byte address width. Tag is addr[ADDR_W-1:2]; addr[1:0] is ignored.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- cpu_req  input  1  request valid. Sampled only while cpu_ready=1.
- cpu_we  input  1  1=write, 0=read.
- cpu_addr  input  ADDR_W  request address.
- cpu_wdata  input  DATA_W  write data.
- cpu_ready  output  1  high only in IDLE. A request is accepted on a posedge with cpu_req&cpu_ready.
- cpu_done  output  1  one-cycle completion pulse for both reads and writes.
- cpu_rdata  output  DATA_W  read data. Valid while cpu_done=1 for reads; holds its last value otherwise.
- mem_req  output  1  memory request. Held until mem_ack.
- mem_we  output  1  memory write.
- mem_addr  output  ADDR_W  registered request address, with low 2 bits forced to 0.
- mem_wdata  output  DATA_W  registered write data.
- mem_ack  input  1  memory completion. Meaningful only while mem_req=1; read data is valid with it.
- mem_rdata  input  DATA_W  memory read data.
- lru_way  output  2  way index to lru (lineIndex).
- lru_hit  output  1  to lru hit; always 1 when lru_en=1.
- lru_en  output  1  one-cycle pulse; lru updates its counters (on negedge) while this is high.
- lru_victim  input  2  lruOut from lru.

Behaviour:
- Reset:
  - state=IDLE; valid[3:0]=0; cpu_done, mem_req, mem_we, lru_en = 0.
  - cpu_rdata, mem_addr, mem_wdata = 0; lru_way=0, lru_hit=0.
  - Tag and data arrays are not reset.
- Reset mid-operation: the next posedge forces IDLE and drops mem_req. Any outstanding memory transaction is abandoned, and a late mem_ack is ignored.
- States: IDLE, COMPARE, MEM_RD, MEM_WR, RESP.
- IDLE:
  - cpu_ready=1.
  - On accept: register we/addr/wdata, go to COMPARE.
- COMPARE: combinational tag match against valid ways. If several ways match, the lowest index wins.
  - Read hit:
    - lru_en=1, lru_way=hit way.
    - Register cpu_rdata from data[hit way]; go to RESP.
  - Read miss:
    - Latch fill way: the lowest-index invalid way if any, else lru_victim sampled this cycle.
    - Go to MEM_RD.
  - Write hit:
    - data[hit way] <= wdata; lru_en=1, lru_way=hit way.
    - Go to MEM_WR.
  - Write miss: go to MEM_WR. No lru update, no allocation.
- MEM_RD:
  - mem_req=1, mem_we=0.
  - On mem_ack:
    - tag[fill] <= addr tag; data[fill] <= mem_rdata; valid[fill] <= 1.
    - cpu_rdata <= mem_rdata; lru_en=1, lru_way=fill way.
    - Go to RESP.
- MEM_WR:
  - mem_req=1, mem_we=1.
  - On mem_ack, go to RESP.
- RESP:
  - cpu_done=1 for exactly one cycle; go to IDLE.
  - Back-to-back requests therefore have a minimum spacing of 3 cycles.
- Latency:
  - Read hit: cpu_done is high in the 2nd cycle after the accepting edge.
  - Miss or any write: cpu_done is high in the cycle after the mem_ack edge.
- mem_ack is allowed in the same cycle mem_req first rises; it completes immediately.
- cpu_req while busy is not accepted; the requester holds it.
- Fills never evict when an invalid way exists. With all 4 valid, the victim is exactly lru_victim.

Decomposition:
- cache_pkg holds:
  - state enum (IDLE, COMPARE, MEM_RD, MEM_WR, RESP);
  - WAYS=4, WAY_W=2;
  - a tag-width function of ADDR_W.
- Sub-module cache_tag_match: 4 tag comparators gated by valid, plus a priority encoder.
  - Outputs: hit, hit_way[1:0], any_invalid, first_invalid[1:0].

Test Plan:
- Reset, then read 0x100 with mem_rdata=0xAAAA0001 and ack after 3 cycles.
  - Required: mem_req with mem_addr=0x100; fill way 0; lru_en with lru_way=0; cpu_done with rdata=0xAAAA0001; valid=0001.
- Read 0x100 again.
  - Required: no mem_req; lru_en with lru_way=0; cpu_done with rdata=0xAAAA0001 two cycles after accept.
- Fill 0x100, 0x200, 0x300, 0x400 (ways 0-3), then read 0x500 with lru_victim=2.
  - Required: way 2 replaced; a later read of 0x300 misses; a later read of 0x500 hits in way 2.
- Write 0x200 with wdata=0x12345678 after a fill.
  - Required: mem_req/mem_we with mem_wdata=0x12345678; lru_en with lru_way=1; a later read of 0x200 hits and returns 0x12345678.
- Write to 0x900 (miss).
  - Required: mem write issued; no lru_en; valid unchanged; a later read of 0x900 misses.
- Assert reset while in MEM_RD before mem_ack.
  - Required: mem_req=0 and state IDLE next cycle; a mem_ack pulse afterwards causes no fill and no cpu_done; valid=0000.
